// File: rtl/imem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imem_pkg : shared state encoding and defaults for the imem responder |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package imem_pkg;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_3000;
    localparam int          DEFAULT_DEPTH     = 2048;
    localparam int          CNT_W             = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } imem_state_e;

    // Keeps the word-index ports at least one bit wide for a single-word array.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_array.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imem_array : word array, synchronous write, combinational read       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module imem_array
    import imem_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = addr_width(DEPTH)
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [31:0]       i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [31:0]       o_rd_data
);

    logic [31:0] mem_q [DEPTH];

    // No reset: program contents must survive a responder reset.
    always_ff @(posedge clk) begin
        if (i_wr_en && (32'(i_wr_addr) < 32'(DEPTH))) begin
            mem_q[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = mem_q[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/imem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imem_responder : fixed-latency instruction fetch responder           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module imem_responder
    import imem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int          DEPTH     = DEFAULT_DEPTH,
    parameter int          LATENCY   = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [31:0]                  req_pc,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [31:0]                  rsp_instr,
    output logic [31:0]                  rsp_pc,
    output logic                         rsp_err,
    input  logic                         ld_we,
    input  logic [addr_width(DEPTH)-1:0] ld_addr,
    input  logic [31:0]                  ld_data
);

    localparam int               ADDR_W    = addr_width(DEPTH);
    localparam logic [31:0]      MEM_BYTES = 32'(4 * DEPTH);
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    imem_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      rsp_instr_q, rsp_instr_d;
    logic [31:0]      rsp_pc_q, rsp_pc_d;
    logic             rsp_err_q, rsp_err_d;

    logic [31:0]       w_offset;
    logic              w_err;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [31:0]       w_rd_data;

    // Range test on the offset so BASE_ADDR + 4*DEPTH never has to be formed.
    assign w_offset  = pc_q - BASE_ADDR;
    assign w_err     = (pc_q[1:0] != 2'b00) || (pc_q < BASE_ADDR) || (w_offset >= MEM_BYTES);
    assign w_rd_addr = w_offset[ADDR_W+1:2];

    imem_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk       (clk),
        .i_wr_en   (ld_we),
        .i_wr_addr (ld_addr),
        .i_wr_data (ld_data),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_d        = pc_q;
        rsp_instr_d = rsp_instr_q;
        rsp_pc_d    = rsp_pc_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    pc_d    = req_pc;
                    cnt_d   = CNT_LOAD;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    rsp_instr_d = w_err ? 32'h0 : w_rd_data;
                    rsp_pc_d    = pc_q;
                    rsp_err_d   = w_err;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pc_q        <= '0;
            rsp_instr_q <= '0;
            rsp_pc_q    <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pc_q        <= pc_d;
            rsp_instr_q <= rsp_instr_d;
            rsp_pc_q    <= rsp_pc_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_instr = rsp_instr_q;
    assign rsp_pc    = rsp_pc_q;
    assign rsp_err   = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_imem_responder : scoreboard bench with a word-array reference     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_imem_responder;

    localparam logic [31:0] BASE    = 32'h0000_3000;
    localparam int          DEPTH   = 2048;
    localparam int          LATENCY = 2;
    localparam int          AW      = 11;

    logic          clk;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [31:0]   req_pc;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_instr;
    logic [31:0]   rsp_pc;
    logic          rsp_err;
    logic          ld_we;
    logic [AW-1:0] ld_addr;
    logic [31:0]   ld_data;

    imem_responder #(
        .BASE_ADDR (BASE),
        .DEPTH     (DEPTH),
        .LATENCY   (LATENCY)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_pc    (req_pc),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_pc    (rsp_pc),
        .rsp_err   (rsp_err),
        .ld_we     (ld_we),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        err;
        int          stamp;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ref_mem [DEPTH];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          last_accept = 0;
    bit          in_rsp = 0;
    bit          rnd_on = 0;
    int          first_cyc = 0;
    logic [31:0] hold_instr, hold_pc;
    logic        hold_err;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: fetch is a plain array lookup guarded by alignment and range rules.
    function automatic void model(input logic [31:0] pc, output logic [31:0] instr, output logic err);
        longint unsigned a  = longint'(pc);
        longint unsigned lo = longint'(BASE);
        longint unsigned hi = longint'(BASE) + 4 * longint'(DEPTH);
        if ((a % 4) != 0 || a < lo || a >= hi) begin
            err   = 1'b1;
            instr = 32'h0;
        end else begin
            err   = 1'b0;
            instr = ref_mem[int'((a - lo) / 4)];
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int idx, input logic [31:0] d);
        ld_we   = 1'b1;
        ld_addr = AW'(idx);
        ld_data = d;
        tick();
        ld_we   = 1'b0;
        ref_mem[idx] = d;
    endtask

    task automatic issue(input logic [31:0] pc);
        exp_t        e;
        logic [31:0] ei;
        logic        ee;
        int          n = 0;
        model(pc, ei, ee);
        e.pc    = pc;
        e.instr = ei;
        e.err   = ee;
        req_valid = 1'b1;
        req_pc    = pc;
        while (!req_ready && n < 200) begin
            tick();
            n++;
        end
        if (!req_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: req_ready got 0 expected 1 for pc %h", pc);
            req_valid = 1'b0;
            return;
        end
        e.stamp     = cyc;
        last_accept = cyc;
        sb.push_back(e);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || rsp_valid) && n < 300) begin
            tick();
            n++;
        end
        chk("drain_outstanding", 32'(sb.size()), 32'd0);
    endtask

    // Monitor: samples at the falling edge, i.e. the values the next rising edge will act on.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                in_rsp = 1'b0;
            end else if (rsp_valid) begin
                if (!in_rsp) begin
                    in_rsp     = 1'b1;
                    first_cyc  = cyc;
                    hold_instr = rsp_instr;
                    hold_pc    = rsp_pc;
                    hold_err   = rsp_err;
                end else begin
                    chk("hold_instr", rsp_instr, hold_instr);
                    chk("hold_pc", rsp_pc, hold_pc);
                    chk("hold_err", 32'(rsp_err), 32'(hold_err));
                end
                if (rsp_ready) begin
                    in_rsp = 1'b0;
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_rsp: got response pc %h expected none", rsp_pc);
                    end else begin
                        e = sb.pop_front();
                        chk("rsp_instr", rsp_instr, e.instr);
                        chk("rsp_pc", rsp_pc, e.pc);
                        chk("rsp_err", 32'(rsp_err), 32'(e.err));
                        chk("latency", 32'(first_cyc - e.stamp), 32'(LATENCY + 1));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [31:0] pc;
        logic [31:0] old;
        int          n;
        int          st[4];

        reset     = 1'b0;
        req_valid = 1'b0;
        req_pc    = 32'h0;
        rsp_ready = 1'b0;
        ld_we     = 1'b0;
        ld_addr   = '0;
        ld_data   = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_instr", rsp_instr, 32'h0);
        chk("reset_rsp_pc", rsp_pc, 32'h0);
        chk("reset_rsp_err", 32'(rsp_err), 32'd0);
        reset = 1'b1;
        tick();
        chk("reset_req_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < DEPTH; i++) load(i, $urandom());

        // Program load then first fetch
        rsp_ready = 1'b1;
        load(0, 32'h3C01_0001);
        issue(32'h0000_3000);
        drain();

        // Backpressure: hold the response for five cycles
        rsp_ready = 1'b0;
        issue(32'h0000_3008);
        n = 0;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
        chk("bp_rsp_valid_rise", 32'(rsp_valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp_idle_req_ready", 32'(req_ready), 32'd1);
        chk("bp_idle_rsp_valid", 32'(rsp_valid), 32'd0);

        // Address faults and the last legal word
        issue(32'h0000_3002);
        issue(32'h0000_2FFC);
        issue(32'h0000_5000);
        issue(32'h0000_4FFC);
        drain();

        // Load write on the final ACCESS edge of a read of the same word
        old = ref_mem[1];
        issue(32'h0000_3004);
        repeat (LATENCY - 1) tick();
        load(1, old ^ 32'hA5A5_5A5A);
        drain();
        issue(32'h0000_3004);
        drain();

        // Reset while a request is in ACCESS
        issue(32'h0000_3010);
        tick();
        reset = 1'b0;
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_pc", rsp_pc, 32'h0);
        chk("rst_rsp_instr", rsp_instr, 32'h0);
        sb.delete();
        tick();
        tick();
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("rst_no_stale", 32'(rsp_valid), 32'd0);
        end
        issue(32'h0000_3010);
        drain();

        // Back-to-back throughput
        for (int k = 0; k < 4; k++) begin
            issue(BASE + 32'(4 * $urandom_range(0, DEPTH - 1)));
            st[k] = last_accept;
        end
        for (int k = 1; k < 4; k++) chk("throughput_gap", 32'(st[k] - st[k-1]), 32'(LATENCY + 2));
        drain();

        // Randomized traffic with random response backpressure
        rnd_on = 1'b1;
        fork
            begin
                while (rnd_on) begin
                    rsp_ready = ($urandom_range(0, 3) != 0);
                    tick();
                end
                rsp_ready = 1'b1;
            end
        join_none
        for (int it = 0; it < 150; it++) begin
            if ($urandom_range(0, 3) == 0) load(int'($urandom_range(0, DEPTH - 1)), $urandom());
            case ($urandom_range(0, 5))
                0:       pc = $urandom();
                1:       pc = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
                2:       pc = BASE - 32'(4 * $urandom_range(1, 16));
                3:       pc = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 16));
                default: pc = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
            endcase
            issue(pc);
            drain();
        end
        rnd_on = 1'b0;
        tick();
        tick();
        rsp_ready = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000: byte address of instruction word 0.
REQ-002 SHALL have parameter DEPTH, default 2048: number of 32-bit instruction words.
REQ-003 SHALL have parameter LATENCY, default 2, legal range 1..15: cycles spent in ACCESS per request.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port req_valid, input, 1: fetch request present.
REQ-007 SHALL have port req_ready, output, 1: request accepted this cycle if req_valid is also 1.
REQ-008 SHALL have port req_pc, input, 32: byte address of the requested instruction.
REQ-009 SHALL have port rsp_valid, output, 1: response present.
REQ-010 SHALL have port rsp_ready, input, 1: initiator consumes the response.
REQ-011 SHALL have port rsp_instr, output, 32: fetched instruction word.
REQ-012 SHALL have port rsp_pc, output, 32: echo of the accepted req_pc.
REQ-013 SHALL have port rsp_err, output, 1: address fault flag for this response.
REQ-014 SHALL have port ld_we, input, 1: program-load write enable.
REQ-015 SHALL have port ld_addr, input, clog2(DEPTH): word index for the load write.
REQ-016 SHALL have port ld_data, input, 32: load write data.

Function
REQ-017 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-018 SHALL drive req_ready=1 only in IDLE; in IDLE, req_valid=1 SHALL latch req_pc, load the counter with LATENCY-1, and go to ACCESS.
REQ-019 SHALL in ACCESS decrement the counter each cycle and, at counter 0, read the memory, register rsp_instr/rsp_pc/rsp_err, and go to RESP.
REQ-020 SHALL make the request-to-rsp_valid latency exactly LATENCY+1 cycles.
REQ-021 SHALL drive rsp_valid=1 only in RESP, hold rsp_* stable while rsp_ready=0, and return to IDLE on rsp_ready=1.
REQ-022 SHALL NOT accept a new request in the cycle rsp_ready is consumed; acceptance resumes on the next IDLE cycle, so the back-to-back period is LATENCY+2 cycles.
REQ-023 SHALL compute the word index as (req_pc - BASE_ADDR) >> 2 in 32-bit unsigned arithmetic.
REQ-024 SHALL set rsp_err=1 and rsp_instr=32'h0 when req_pc[1:0]!=0, req_pc<BASE_ADDR, or req_pc>=BASE_ADDR+4*DEPTH, with latency unchanged.
REQ-025 SHALL write ld_data to word ld_addr on any cycle with ld_we=1, in any state.
REQ-026 SHALL return the old word on a load write and an ACCESS read to the same word at the same edge (read-before-write).
REQ-027 SHALL make a load write visible to any read at a later edge.
REQ-028 SHALL ignore ld_addr>=DEPTH.

Reset
REQ-029 SHALL on reset=0, immediately and asynchronously, set the state to IDLE, the counter to 0, rsp_valid=0, rsp_instr=0, rsp_pc=0, rsp_err=0, and req_ready=1 after release.
REQ-030 SHALL leave memory contents unchanged by reset and SHALL abandon any in-flight request without producing a response.

Structure
REQ-031 SHALL place the FSM state enum and BASE_ADDR/DEPTH defaults in a shared package, imem_pkg.
REQ-032 SHALL have exactly one sub-module, imem_array: a synchronous-write, combinational-read word array.

Verification
REQ-033 SHALL verify load: ld_addr=0 with 32'h3C010001, then request req_pc=32'h3000 -> rsp_valid on the 3rd cycle after accept, rsp_instr=32'h3C010001, rsp_pc=32'h3000, rsp_err=0.
REQ-034 SHALL verify backpressure: rsp_ready held 0 for 5 cycles -> rsp_* stable, req_ready=0 throughout; rsp_ready=1 -> IDLE next cycle.
REQ-035 SHALL verify faults: req_pc=32'h3002, then 32'h2FFC, then 32'h5000 -> each response has rsp_err=1, rsp_instr=0; req_pc=32'h4FFC -> rsp_err=0.
REQ-036 SHALL verify same-edge collision: ld_we to word 1 on the final ACCESS cycle of req_pc=32'h3004 -> old word returned; a repeat request returns the new word.
REQ-037 SHALL verify reset mid-ACCESS: reset=0 asserted -> rsp_valid=0 immediately; after release, no stale response and the next request completes normally.
REQ-038 SHALL verify throughput: 4 back-to-back requests with rsp_ready=1 -> accepts spaced exactly 4 cycles apart with LATENCY=2.
